// File: rtl/acc_adc_pkg.sv
// Shared definitions for the serial ADC front end.
//   adc_state_e : controller FSM states
//   ADC_*       : default frame constants (AD7476-class, 16-bit frame)
//   cnt_width() : counter width that never collapses to zero bits
package acc_adc_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        DONE     = 3'd3,
        QUIET    = 3'd4
    } adc_state_e;

    localparam int unsigned ADC_CLK_DIV    = 4;
    localparam int unsigned ADC_FRAME_BITS = 16;
    localparam int unsigned ADC_LEAD_BITS  = 4;
    localparam int unsigned ADC_DATA_W     = 12;
    localparam int unsigned ADC_QUIET_CYC  = 2;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SPI clock generator for the ADC front end.
//   clk, rst    : system clock, synchronous active-high reset
//   en          : run the divider; when low SCLK idles high and the divider is primed
//   sclk        : registered SPI clock
//   rise_pulse  : the coming enabled edge drives sclk 0->1
//   fall_pulse  : the coming enabled edge drives sclk 1->0
module adc_sclk_gen
    import acc_adc_pkg::*;
#(
    parameter int unsigned CLK_DIV = ADC_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int unsigned       DIV_W    = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             sclk_q, sclk_d;
    logic             tc;

    // Pulses depend only on local registers, never on en, so the parent can
    // use them to compute en without forming a loop. While idle the divider
    // sits at its terminal count, so the first enabled edge drops SCLK.
    assign tc         = (div_cnt_q == DIV_LAST);
    assign rise_pulse = tc && !sclk_q;
    assign fall_pulse = tc && sclk_q;
    assign sclk       = sclk_q;

    always_comb begin
        div_cnt_d = div_cnt_q;
        sclk_d    = sclk_q;
        if (!en) begin
            div_cnt_d = DIV_LAST;
            sclk_d    = 1'b1;
        end else if (tc) begin
            div_cnt_d = '0;
            sclk_d    = !sclk_q;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= DIV_LAST;
            sclk_q    <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
        end
    end

endmodule

// File: rtl/adc_spi_ctrl.sv
// Serial ADC front end: runs continuous SPI read frames on an AD7476-class
// converter and presents each sample with a one-cycle valid strobe.
//   clk, rst        : system clock, synchronous active-high reset
//   conv_en         : keep converting while high
//   adc_sdo         : serial data from the ADC
//   adc_cs_n        : chip select, active low
//   adc_sclk        : SPI clock, idles high
//   adc_data_out    : last completed sample, held between frames
//   adc_data_valid  : one-cycle pulse when adc_data_out updates
//   frame_err       : leading bits of the last frame were not all zero
//   busy            : FSM not in IDLE
//
// state    | meaning
// IDLE     | CS_n high, SCLK high, waiting for conv_en
// CS_SETUP | CS_n low, SCLK high for CLK_DIV cycles
// SHIFT    | FRAME_BITS SCLK periods, sample adc_sdo on each rising edge
// DONE     | one cycle: CS_n high, latch sample and frame error
// QUIET    | CS_n high for QUIET_CYC cycles, then next frame or IDLE
module adc_spi_ctrl
    import acc_adc_pkg::*;
#(
    parameter int unsigned CLK_DIV    = ADC_CLK_DIV,
    parameter int unsigned FRAME_BITS = ADC_FRAME_BITS,
    parameter int unsigned LEAD_BITS  = ADC_LEAD_BITS,
    parameter int unsigned DATA_W     = ADC_DATA_W,
    parameter int unsigned QUIET_CYC  = ADC_QUIET_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              conv_en,
    input  logic              adc_sdo,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [DATA_W-1:0] adc_data_out,
    output logic              adc_data_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned      BIT_W      = $clog2(FRAME_BITS + 1);
    localparam int unsigned      TMR_MAX    = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
    localparam int unsigned      TMR_W      = cnt_width(TMR_MAX);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS);
    localparam logic [TMR_W-1:0] CS_LOAD    = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] QUIET_LOAD = TMR_W'(QUIET_CYC - 1);

    adc_state_e              state_q, state_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    ferr_q, ferr_d;
    logic                    valid_q, valid_d;
    logic                    cs_n_q, cs_n_d;
    logic                    busy_q, busy_d;
    logic                    sclk_en, rise_pulse, fall_pulse, tmr_zero;

    adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .en         (sclk_en),
        .sclk       (adc_sclk),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    assign tmr_zero = (tmr_q == '0);

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ferr_d    = ferr_q;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (conv_en) begin
                    state_d   = CS_SETUP;
                    tmr_d     = CS_LOAD;
                    bit_cnt_d = '0;
                end
            end
            CS_SETUP: begin
                if (tmr_zero) state_d = SHIFT;
                else          tmr_d   = tmr_q - 1'b1;
            end
            SHIFT: begin
                if (rise_pulse) begin
                    shift_d   = {shift_q[FRAME_BITS-2:0], adc_sdo};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (fall_pulse && (bit_cnt_q == BIT_LAST)) begin
                    // last high half-period served; leave SCLK high
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = QUIET;
                tmr_d   = QUIET_LOAD;
                data_d  = shift_q[FRAME_BITS-LEAD_BITS-1 -: DATA_W];
                ferr_d  = |shift_q[FRAME_BITS-1 -: LEAD_BITS];
                valid_d = 1'b1;
            end
            QUIET: begin
                if (!tmr_zero) begin
                    tmr_d = tmr_q - 1'b1;
                end else if (conv_en) begin
                    state_d   = CS_SETUP;
                    tmr_d     = CS_LOAD;
                    bit_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        sclk_en = (state_d == SHIFT);
        cs_n_d  = !((state_d == CS_SETUP) || (state_d == SHIFT));
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ferr_q    <= 1'b0;
            valid_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ferr_q    <= ferr_d;
            valid_q   <= valid_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
        end
    end

    assign adc_cs_n       = cs_n_q;
    assign adc_data_out   = data_q;
    assign adc_data_valid = valid_q;
    assign frame_err      = ferr_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_adc_spi_ctrl.sv
module tb_adc_spi_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        conv_en = 1'b0;
    logic        adc_sdo = 1'b0;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic [11:0] adc_data_out;
    logic        adc_data_valid;
    logic        frame_err;
    logic        busy;

    int checks = 0;
    int failures = 0;

    adc_spi_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .conv_en        (conv_en),
        .adc_sdo        (adc_sdo),
        .adc_cs_n       (adc_cs_n),
        .adc_sclk       (adc_sclk),
        .adc_data_out   (adc_data_out),
        .adc_data_valid (adc_data_valid),
        .frame_err      (frame_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // ADC model: first bit on CS_n fall, next bit after every SCLK rise.
    logic [15:0] wq[$];
    logic [15:0] cur_word = 16'h0;
    int          bit_idx = 16;
    int          rise_cnt = 0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b1;

    always @(posedge clk) begin
        #1;
        if (prev_cs && !adc_cs_n) begin
            cur_word = (wq.size() > 0) ? wq.pop_front() : 16'h0;
            bit_idx = 0;
        end else if (!adc_cs_n && !prev_sclk && adc_sclk) begin
            bit_idx++;
            rise_cnt++;
        end
        adc_sdo = (bit_idx < 16) ? cur_word[4'(15 - bit_idx)] : 1'b0;
        prev_cs = adc_cs_n;
        prev_sclk = adc_sclk;
    end

    // Passive monitors
    int valid_cnt = 0;
    int cs_low_cnt = 0;
    int hi_run = 0;
    int last_gap = 0;

    always @(negedge clk) begin
        if (adc_data_valid === 1'b1) valid_cnt++;
        if (adc_cs_n === 1'b0) begin
            cs_low_cnt++;
            if (hi_run > 0) last_gap = hi_run;
            hi_run = 0;
        end else begin
            hi_run++;
        end
    end

    task automatic wait_valid(input int max_cyc, output int n, output bit got);
        n = 0;
        got = 1'b0;
        while (n < max_cyc && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (adc_data_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        int bad = 0;
        int v0;
        rst = 1'b1;
        conv_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        v0 = valid_cnt;
        repeat (50) begin
            @(negedge clk);
            if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL reset_idle_cycles bad=%0d expected=0", bad); end
        checks++;
        if (adc_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b expected=1", adc_cs_n); end
        checks++;
        if (adc_sclk !== 1'b1) begin failures++; $display("FAIL reset_sclk got=%b expected=1", adc_sclk); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b expected=0", busy); end
        checks++;
        if (adc_data_out !== 12'h000) begin failures++; $display("FAIL reset_data got=%h expected=000", adc_data_out); end
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b expected=0", frame_err); end
        checks++;
        if (valid_cnt - v0 !== 0) begin failures++; $display("FAIL reset_valid_count got=%0d expected=0", valid_cnt - v0); end
    endtask

    task automatic test_single;
        int n, r0, v0;
        bit got, ok;
        wq.push_back(16'h0A5C);
        r0 = rise_cnt;
        v0 = valid_cnt;
        @(negedge clk);
        conv_en = 1'b1;
        @(posedge clk);
        #1;
        conv_en = 1'b0;
        wait_valid(300, n, got);
        checks++;
        if (!got || n !== 133) begin failures++; $display("FAIL single_latency got=%0d (seen=%0d) expected=133", n, got); end
        checks++;
        if (adc_data_out !== 12'hA5C) begin failures++; $display("FAIL single_data got=%h expected=a5c", adc_data_out); end
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL single_ferr got=%b expected=0", frame_err); end
        @(posedge clk);
        #1;
        checks++;
        if (adc_data_valid !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%b expected=0", adc_data_valid); end
        wait_idle(50, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_idle busy=%b expected=0", busy); end
        checks++;
        if (rise_cnt - r0 !== 16) begin failures++; $display("FAIL single_sclk_rises got=%0d expected=16", rise_cnt - r0); end
        checks++;
        if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL single_valid_count got=%0d expected=1", valid_cnt - v0); end
    endtask

    task automatic test_continuous;
        int n;
        bit got, ok;
        wq.push_back(16'h0FFF);
        wq.push_back(16'h0000);
        wq.push_back(16'h0123);
        @(negedge clk);
        conv_en = 1'b1;
        wait_valid(300, n, got);
        checks++;
        if (!got || adc_data_out !== 12'hFFF) begin failures++; $display("FAIL cont_data0 got=%h (seen=%0d) expected=fff", adc_data_out, got); end
        wait_valid(300, n, got);
        checks++;
        if (!got || n !== 135) begin failures++; $display("FAIL cont_period1 got=%0d expected=135", n); end
        checks++;
        if (adc_data_out !== 12'h000) begin failures++; $display("FAIL cont_data1 got=%h expected=000", adc_data_out); end
        checks++;
        if (last_gap !== 3) begin failures++; $display("FAIL cont_cs_gap1 got=%0d expected=3", last_gap); end
        wait_valid(300, n, got);
        conv_en = 1'b0;
        checks++;
        if (!got || n !== 135) begin failures++; $display("FAIL cont_period2 got=%0d expected=135", n); end
        checks++;
        if (adc_data_out !== 12'h123) begin failures++; $display("FAIL cont_data2 got=%h expected=123", adc_data_out); end
        checks++;
        if (last_gap !== 3) begin failures++; $display("FAIL cont_cs_gap2 got=%0d expected=3", last_gap); end
        wait_idle(50, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL cont_idle busy=%b expected=0", busy); end
    endtask

    task automatic test_frame_err;
        int n;
        bit got, ok;
        wq.push_back(16'h8001);
        wq.push_back(16'h0001);
        @(negedge clk);
        conv_en = 1'b1;
        wait_valid(300, n, got);
        checks++;
        if (!got || adc_data_out !== 12'h001) begin failures++; $display("FAIL ferr_data0 got=%h expected=001", adc_data_out); end
        checks++;
        if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_set got=%b expected=1", frame_err); end
        repeat (10) @(negedge clk);
        checks++;
        if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_held got=%b expected=1", frame_err); end
        wait_valid(300, n, got);
        conv_en = 1'b0;
        checks++;
        if (!got || adc_data_out !== 12'h001) begin failures++; $display("FAIL ferr_data1 got=%h expected=001", adc_data_out); end
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clear got=%b expected=0", frame_err); end
        wait_idle(50, ok);
    endtask

    task automatic test_abort;
        int n, r0, v0, low0;
        bit got, ok;
        bit reached = 1'b0;
        wq.push_back(16'h0ABC);
        r0 = rise_cnt;
        v0 = valid_cnt;
        @(negedge clk);
        conv_en = 1'b1;
        for (int i = 0; i < 300 && !reached; i++) begin
            @(negedge clk);
            if (rise_cnt - r0 >= 5) reached = 1'b1;
        end
        conv_en = 1'b0;
        checks++;
        if (!reached) begin failures++; $display("FAIL abort_reach_bit5 rises=%0d expected=5", rise_cnt - r0); end
        wait_valid(300, n, got);
        checks++;
        if (!got || adc_data_out !== 12'hABC) begin failures++; $display("FAIL abort_data got=%h (seen=%0d) expected=abc", adc_data_out, got); end
        wait_idle(50, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL abort_idle busy=%b expected=0", busy); end
        low0 = cs_low_cnt;
        repeat (200) @(negedge clk);
        checks++;
        if (cs_low_cnt !== low0) begin failures++; $display("FAIL abort_no_second_frame cs_low_cycles=%0d expected=0", cs_low_cnt - low0); end
        checks++;
        if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL abort_valid_count got=%0d expected=1", valid_cnt - v0); end
    endtask

    task automatic test_reset_mid;
        int n, r0, r1, v0;
        bit got, ok;
        bit reached = 1'b0;
        wq.push_back(16'h0777);
        wq.push_back(16'h0555);
        r0 = rise_cnt;
        @(negedge clk);
        conv_en = 1'b1;
        for (int i = 0; i < 300 && !reached; i++) begin
            @(negedge clk);
            if (rise_cnt - r0 >= 9) reached = 1'b1;
        end
        rst = 1'b1;
        v0 = valid_cnt;
        @(posedge clk);
        #1;
        checks++;
        if (!reached || adc_cs_n !== 1'b1) begin failures++; $display("FAIL rstmid_cs_n got=%b (bit9=%0d) expected=1", adc_cs_n, reached); end
        checks++;
        if (adc_sclk !== 1'b1) begin failures++; $display("FAIL rstmid_sclk got=%b expected=1", adc_sclk); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b expected=0", busy); end
        checks++;
        if (adc_data_out !== 12'h000) begin failures++; $display("FAIL rstmid_data got=%h expected=000", adc_data_out); end
        checks++;
        if (adc_data_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b expected=0", adc_data_valid); end
        @(negedge clk);
        rst = 1'b0;
        r1 = rise_cnt;
        @(posedge clk);
        wait_valid(300, n, got);
        conv_en = 1'b0;
        checks++;
        if (!got || n !== 133) begin failures++; $display("FAIL rstmid_restart_latency got=%0d expected=133", n); end
        checks++;
        if (adc_data_out !== 12'h555 || frame_err !== 1'b0) begin failures++; $display("FAIL rstmid_restart_data got=%h/%b expected=555/0", adc_data_out, frame_err); end
        wait_idle(50, ok);
        checks++;
        if (rise_cnt - r1 !== 16) begin failures++; $display("FAIL rstmid_sclk_rises got=%0d expected=16", rise_cnt - r1); end
        checks++;
        if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL rstmid_valid_count got=%0d expected=1", valid_cnt - v0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_continuous();
        test_frame_err();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
